mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets REQ_COUNT requesters share one memory_controller port.
// Each requester has one pending slot, and only one command is outstanding downstream at a time.
module mem_port_arbiter #(
  parameter int unsigned REQ_COUNT       = 2,
  parameter int unsigned DATA_WIDTH_BYTE = 4,
  parameter int unsigned ADDR_WIDTH_BYTE = 4,
  localparam int unsigned DATA_WIDTH     = 8 * DATA_WIDTH_BYTE,
  localparam int unsigned ADDR_WIDTH     = 8 * ADDR_WIDTH_BYTE
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [REQ_COUNT*2-1:0]               req_rw_flag_,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0]      req_addr_,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0]      req_write_data_,
  input  logic [REQ_COUNT*DATA_WIDTH_BYTE-1:0] req_write_mask_,
  output logic [REQ_COUNT*DATA_WIDTH-1:0]      req_read_data_,
  output logic [REQ_COUNT-1:0]                 req_busy,
  output logic [REQ_COUNT-1:0]                 req_done,
  output logic [1:0]                           mem_rw_flag,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_write_data,
  output logic [DATA_WIDTH_BYTE-1:0]           mem_write_mask,
  input  logic [DATA_WIDTH-1:0]                mem_read_data,
  input  logic                                 mem_busy,
  input  logic                                 mem_done
);

  localparam int unsigned PtrW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                                        state_q, state_d;
  logic [PtrW-1:0]                               ptr_q, ptr_d;
  logic [PtrW-1:0]                               grant_q, grant_d;
  logic [REQ_COUNT-1:0]                          valid_q, valid_d;
  logic [REQ_COUNT-1:0]                          is_write_q, is_write_d;
  logic [REQ_COUNT-1:0][ADDR_WIDTH-1:0]          slot_addr_q, slot_addr_d;
  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]          slot_data_q, slot_data_d;
  logic [REQ_COUNT-1:0][DATA_WIDTH_BYTE-1:0]     slot_mask_q, slot_mask_d;
  logic [REQ_COUNT-1:0][DATA_WIDTH-1:0]          read_data_q, read_data_d;
  logic [REQ_COUNT-1:0]                          done_q, done_d;
  logic [1:0]                                    mem_flag_q, mem_flag_d;
  logic [ADDR_WIDTH-1:0]                         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]                         mem_data_q, mem_data_d;
  logic [DATA_WIDTH_BYTE-1:0]                    mem_mask_q, mem_mask_d;

  logic                                          found;
  logic [PtrW-1:0]                               sel;
  logic [PtrW-1:0]                               cand;
  logic [1:0]                                    cmd;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    valid_d     = valid_q;
    is_write_d  = is_write_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_mask_d = slot_mask_q;
    read_data_d = read_data_q;
    done_d      = '0;
    mem_flag_d  = 2'd0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_mask_d  = mem_mask_q;
    found       = 1'b0;
    sel         = '0;
    cand        = '0;
    cmd         = 2'd0;

    // A busy requester's inputs are ignored, so a slot is never overwritten while owned.
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      cmd = req_rw_flag_[i*2 +: 2];
      if (!valid_q[i] && (cmd == 2'd1 || cmd == 2'd2)) begin
        valid_d[i]     = 1'b1;
        is_write_d[i]  = (cmd == 2'd2);
        slot_addr_d[i] = req_addr_[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_data_d[i] = req_write_data_[i*DATA_WIDTH +: DATA_WIDTH];
        slot_mask_d[i] = req_write_mask_[i*DATA_WIDTH_BYTE +: DATA_WIDTH_BYTE];
      end
    end

    // First pending slot at or after ptr, wrapping.
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % REQ_COUNT);
      if (!found && valid_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (found && !mem_busy) begin
          grant_d    = sel;
          mem_flag_d = is_write_q[sel] ? 2'd2 : 2'd1;
          mem_addr_d = slot_addr_q[sel];
          mem_data_d = slot_data_q[sel];
          mem_mask_d = slot_mask_q[sel];
          state_d    = StWait;
        end
      end
      StWait: begin
        if (mem_done) begin
          done_d[grant_q]  = 1'b1;
          valid_d[grant_q] = 1'b0;
          if (!is_write_q[grant_q]) begin
            read_data_d[grant_q] = mem_read_data;
          end
          ptr_d   = (32'(grant_q) == REQ_COUNT - 1) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      valid_q     <= '0;
      is_write_q  <= '0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      slot_mask_q <= '0;
      read_data_q <= '0;
      done_q      <= '0;
      mem_flag_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      valid_q     <= valid_d;
      is_write_q  <= is_write_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_mask_q <= slot_mask_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      mem_flag_q  <= mem_flag_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_mask_q  <= mem_mask_d;
    end
  end

  assign req_read_data_ = read_data_q;
  assign req_busy       = valid_q;
  assign req_done       = done_q;
  assign mem_rw_flag    = mem_flag_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;
  assign mem_write_mask = mem_mask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with two 32-bit requesters.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req_rw_flag_;
  logic [63:0] req_addr_;
  logic [63:0] req_write_data_;
  logic [7:0]  req_write_mask_;
  logic [63:0] req_read_data_;
  logic [1:0]  req_busy;
  logic [1:0]  req_done;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        mem_done;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .REQ_COUNT       (2),
    .DATA_WIDTH_BYTE (4),
    .ADDR_WIDTH_BYTE (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .req_rw_flag_    (req_rw_flag_),
    .req_addr_       (req_addr_),
    .req_write_data_ (req_write_data_),
    .req_write_mask_ (req_write_mask_),
    .req_read_data_  (req_read_data_),
    .req_busy        (req_busy),
    .req_done        (req_done),
    .mem_rw_flag     (mem_rw_flag),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_mask  (mem_write_mask),
    .mem_read_data   (mem_read_data),
    .mem_busy        (mem_busy),
    .mem_done        (mem_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    req_rw_flag_[i*2 +: 2]     = f;
    req_addr_[i*32 +: 32]      = a;
    req_write_data_[i*32 +: 32] = d;
    req_write_mask_[i*4 +: 4]  = m;
  endtask

  initial begin
    RST             = 1'b1;
    req_rw_flag_    = '0;
    req_addr_       = '0;
    req_write_data_ = '0;
    req_write_mask_ = '0;
    mem_read_data   = '0;
    mem_busy        = 1'b0;
    mem_done        = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(req_busy), 64'h0);
    check("rst_done", 64'(req_done), 64'h0);
    check("rst_flag", 64'(mem_rw_flag), 64'h0);
    check("rst_rdata", req_read_data_, 64'h0);
    RST = 1'b0;
    tick();

    // Single read by requester 0, done three cycles after issue
    set_req(0, 2'd1, 32'h100, 32'h0, 4'h0);
    tick();
    check("rd_busy_acc", 64'(req_busy), 64'h1);
    check("rd_flag_acc", 64'(mem_rw_flag), 64'h0);
    set_req(0, 2'd0, 32'h100, 32'h0, 4'h0);
    tick();
    check("rd_issue_flag", 64'(mem_rw_flag), 64'h1);
    check("rd_issue_addr", 64'(mem_addr), 64'h100);
    tick();
    check("rd_flag_pulse", 64'(mem_rw_flag), 64'h0);
    check("rd_addr_hold", 64'(mem_addr), 64'h100);
    tick();
    check("rd_no_done_yet", 64'(req_done), 64'h0);
    mem_done      = 1'b1;
    mem_read_data = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    check("rd_done", 64'(req_done), 64'h1);
    check("rd_busy_clr", 64'(req_busy), 64'h0);
    check("rd_data0", 64'(req_read_data_[31:0]), 64'hDEADBEEF);
    tick();
    check("rd_done_pulse", 64'(req_done), 64'h0);

    // Backpressure: requester 1 held off by mem_busy for five cycles
    mem_busy = 1'b1;
    set_req(1, 2'd1, 32'h200, 32'h0, 4'h0);
    tick();
    set_req(1, 2'd0, 32'h200, 32'h0, 4'h0);
    check("bp_busy1", 64'(req_busy), 64'h2);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_flag", 64'(mem_rw_flag), 64'h0);
    end
    mem_busy = 1'b0;
    tick();
    check("bp_issue_flag", 64'(mem_rw_flag), 64'h1);
    check("bp_issue_addr", 64'(mem_addr), 64'h200);
    mem_done      = 1'b1;
    mem_read_data = 32'h12345678;
    tick();
    mem_done = 1'b0;
    check("bp_done", 64'(req_done), 64'h2);
    check("bp_data1", 64'(req_read_data_[63:32]), 64'h12345678);
    check("bp_data0_kept", 64'(req_read_data_[31:0]), 64'hDEADBEEF);

    // Fairness: req0 writes continuously, req1 reads once; issue order 0,1,0
    set_req(0, 2'd2, 32'h300, 32'hA5A5A5A5, 4'h5);
    set_req(1, 2'd1, 32'h400, 32'h0, 4'h0);
    tick();
    set_req(1, 2'd0, 32'h400, 32'h0, 4'h0);
    check("fair_busy", 64'(req_busy), 64'h3);
    tick();
    check("fair_i0_flag", 64'(mem_rw_flag), 64'h2);
    check("fair_i0_addr", 64'(mem_addr), 64'h300);
    check("fair_i0_data", 64'(mem_write_data), 64'hA5A5A5A5);
    check("fair_i0_mask", 64'(mem_write_mask), 64'h5);
    mem_done      = 1'b1;
    mem_read_data = 32'h55555555;
    tick();
    mem_done = 1'b0;
    check("fair_done0", 64'(req_done), 64'h1);
    check("fair_busy_after0", 64'(req_busy), 64'h2);
    check("fair_wr_keeps_rd0", 64'(req_read_data_[31:0]), 64'hDEADBEEF);
    set_req(0, 2'd2, 32'h500, 32'h11223344, 4'hA);
    tick();
    check("fair_i1_flag", 64'(mem_rw_flag), 64'h1);
    check("fair_i1_addr", 64'(mem_addr), 64'h400);
    check("fair_reacc0", 64'(req_busy), 64'h3);
    mem_done      = 1'b1;
    mem_read_data = 32'hCAFEF00D;
    tick();
    mem_done = 1'b0;
    check("fair_done1", 64'(req_done), 64'h2);
    check("fair_data1", 64'(req_read_data_[63:32]), 64'hCAFEF00D);
    check("fair_payload_hold", 64'(mem_addr), 64'h400);
    tick();
    check("fair_i2_flag", 64'(mem_rw_flag), 64'h2);
    check("fair_i2_addr", 64'(mem_addr), 64'h500);
    check("fair_i2_data", 64'(mem_write_data), 64'h11223344);
    check("fair_i2_mask", 64'(mem_write_mask), 64'hA);
    set_req(0, 2'd0, 32'h0, 32'h0, 4'h0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("fair_done0b", 64'(req_done), 64'h1);
    check("fair_rd0_final", 64'(req_read_data_[31:0]), 64'hDEADBEEF);
    tick();

    // Ignore rules: spurious mem_done, flag 3, command while busy
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("ign_spur_done", 64'(req_done), 64'h0);
    check("ign_spur_flag", 64'(mem_rw_flag), 64'h0);
    set_req(0, 2'd3, 32'h123, 32'h0, 4'h0);
    tick();
    check("ign_f3_busy", 64'(req_busy), 64'h0);
    tick();
    check("ign_f3_flag", 64'(mem_rw_flag), 64'h0);
    mem_busy = 1'b1;
    set_req(0, 2'd2, 32'h600, 32'h66666666, 4'hF);
    tick();
    set_req(0, 2'd2, 32'h700, 32'h77777777, 4'h1);
    tick();
    mem_busy = 1'b0;
    tick();
    check("ign_busy_flag", 64'(mem_rw_flag), 64'h2);
    check("ign_busy_addr", 64'(mem_addr), 64'h600);
    check("ign_busy_data", 64'(mem_write_data), 64'h66666666);
    tick();
    check("ign_wait_flag", 64'(mem_rw_flag), 64'h0);
    set_req(0, 2'd0, 32'h0, 32'h0, 4'h0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("ign_busy_done", 64'(req_done), 64'h1);
    tick();
    check("ign_idle_busy", 64'(req_busy), 64'h0);
    check("ign_idle_flag", 64'(mem_rw_flag), 64'h0);

    // Asynchronous reset during WAIT, then stale mem_done and a fresh read
    set_req(1, 2'd1, 32'h800, 32'h0, 4'h0);
    tick();
    set_req(1, 2'd0, 32'h0, 32'h0, 4'h0);
    tick();
    check("rw_issue_flag", 64'(mem_rw_flag), 64'h1);
    #2;
    RST = 1'b1;
    #1;
    check("async_busy", 64'(req_busy), 64'h0);
    check("async_flag", 64'(mem_rw_flag), 64'h0);
    check("async_addr", 64'(mem_addr), 64'h0);
    check("async_rdata", req_read_data_, 64'h0);
    check("async_wdata", 64'(mem_write_data), 64'h0);
    #1;
    RST = 1'b0;
    mem_done      = 1'b1;
    mem_read_data = 32'h00000BAD;
    tick();
    mem_done = 1'b0;
    check("rw_stale_done", 64'(req_done), 64'h0);
    check("rw_stale_data", req_read_data_, 64'h0);
    set_req(1, 2'd1, 32'h900, 32'h0, 4'h0);
    tick();
    set_req(1, 2'd0, 32'h0, 32'h0, 4'h0);
    tick();
    check("rw_fresh_flag", 64'(mem_rw_flag), 64'h1);
    check("rw_fresh_addr", 64'(mem_addr), 64'h900);
    mem_done      = 1'b1;
    mem_read_data = 32'h0F0F0F0F;
    tick();
    mem_done = 1'b0;
    check("rw_fresh_done", 64'(req_done), 64'h2);
    check("rw_fresh_data", 64'(req_read_data_[63:32]), 64'h0F0F0F0F);
    check("rw_fresh_busy", 64'(req_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
